// File: rtl/booth_seq_mult_if.sv
`default_nettype none
// ============================================================================
//  Module      : booth_seq_mult_if
//  Description : Operand/product handshake bundle for the sequential Booth
//                multiplier. The master supplies operands and accepts
//                products. The slave is the multiplier itself.
//  Revision    : 1.0  initial release
// ============================================================================
interface booth_seq_mult_if #(
   parameter int WIDTH = 16
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 tc;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   prod;
   logic                 busy;

   modport master (
      output in_valid, a, b, tc, out_ready,
      input  in_ready, out_valid, prod, busy
   );

   modport slave (
      input  in_valid, a, b, tc, out_ready,
      output in_ready, out_valid, prod, busy
   );
endinterface
`default_nettype wire

// File: rtl/booth_seq_mult.sv
`default_nettype none
// ============================================================================
//  Module      : booth_seq_mult
//  Description : Iterative radix-2 Booth multiplier. One recode/add/shift step
//                is performed per clock. Operands can be signed or unsigned,
//                and a valid/ready handshake is used on both sides.
//  Revision    : 1.0  initial release
// ============================================================================
module booth_seq_mult #(
   parameter int WIDTH = 16
) (
   input  wire logic          clk,
   input  wire logic          rst,
   booth_seq_mult_if.slave    bus
);

   // The step counter must hold 0..WIDTH.
   localparam int             CW        = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]  LAST_STEP = CW'(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [WIDTH+1:0]      acc_q, acc_d;       // partial-product accumulator
   logic [WIDTH+1:0]      m_q, m_d;           // extended multiplicand
   logic [WIDTH+1:0]      q_q, q_d;           // {extended multiplier, q(-1)}
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [2*WIDTH-1:0]    prod_q, prod_d;
   logic                  in_ready_q, in_ready_d;
   logic                  out_valid_q, out_valid_d;
   logic                  busy_q, busy_d;

   // The operands are extended by one bit, so that an unsigned value always
   // reads as non-negative to the signed Booth recoder.
   logic [WIDTH:0]        ext_a;
   logic [WIDTH:0]        ext_b;
   logic [WIDTH+1:0]      sum;
   logic [WIDTH+1:0]      acc_sh;
   logic [WIDTH+1:0]      q_sh;
   logic [2*WIDTH-1:0]    prod_full;

   // Extend the operands: a sign extension for two's complement, a zero extension otherwise.
   always_comb begin
      ext_a = {bus.tc & bus.a[WIDTH-1], bus.a};
      ext_b = {bus.tc & bus.b[WIDTH-1], bus.b};
   end

   // One Booth step: recode {Q[1],Q[0]}, add or subtract M, then shift {ACC,Q} right arithmetically.
   always_comb begin
      sum = acc_q;
      case ({q_q[1], q_q[0]})
         2'b01:   sum = acc_q + m_q;
         2'b10:   sum = acc_q + ~m_q + {{(WIDTH+1){1'b0}}, 1'b1};
         default: sum = acc_q;
      endcase
      acc_sh    = {sum[WIDTH+1], sum[WIDTH+1:1]};
      q_sh      = {sum[0], q_q[WIDTH+1:1]};
      // These are the low 2*WIDTH bits of {ACC, Q[WIDTH+1:1]} after the shift.
      prod_full = {acc_sh[WIDTH-2:0], q_sh[WIDTH+1:1]};
   end

   // Next-state and next-output logic of the control FSM.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      m_d         = m_q;
      q_d         = q_q;
      cnt_d       = cnt_q;
      prod_d      = prod_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;

      case (state_q)
         S_IDLE: begin
            if (bus.in_valid && in_ready_q) begin
               acc_d      = '0;
               m_d        = {ext_a[WIDTH], ext_a};
               q_d        = {ext_b, 1'b0};
               cnt_d      = '0;
               in_ready_d = 1'b0;
               busy_d     = 1'b1;
               state_d    = S_CALC;
            end
         end
         S_CALC: begin
            acc_d = acc_sh;
            q_d   = q_sh;
            if (cnt_q == LAST_STEP) begin
               prod_d      = prod_full;
               out_valid_d = 1'b1;
               state_d     = S_DONE;
            end else begin
               cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            end
         end
         S_DONE: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               busy_d      = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            busy_d      = 1'b0;
            state_d     = S_IDLE;
         end
      endcase
   end

   // State and datapath registers. Reset aborts any calculation that is in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         acc_q       <= '0;
         m_q         <= '0;
         q_q         <= '0;
         cnt_q       <= '0;
         prod_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         m_q         <= m_d;
         q_q         <= q_d;
         cnt_q       <= cnt_d;
         prod_q      <= prod_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.prod      = prod_q;
   assign bus.busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_seq_mult.sv
`default_nettype none
// ============================================================================
//  Module      : tb_booth_seq_mult
//  Description : Self-checking bench for booth_seq_mult (WIDTH=16). It uses a
//                directed vector table, hand-written handshake/reset sequences
//                and a short randomised sweep against an integer reference.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_booth_seq_mult;

   localparam int W = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   booth_seq_mult_if #(.WIDTH(W)) bus ();

   booth_seq_mult #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          tc;
      logic [15:0]   a;
      logic [15:0]   b;
      logic [31:0]   exp;
   } vec_t;

   vec_t vecs[15];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // This task runs one full transaction. It is entered and left 1ns after a rising edge.
   task automatic do_op(input logic t, input logic [15:0] x, input logic [15:0] y,
                        input int hold, output logic [31:0] p, output int lat,
                        output bit rdy_low);
      int n;
      bus.tc = t; bus.a = x; bus.b = y; bus.in_valid = 1'b1;
      n = 0;
      while (!bus.in_ready && n < 200) begin tick(); n++; end
      tick();                                   // acceptance edge
      bus.in_valid = 1'b0;
      bus.a = ~x; bus.b = ~y; bus.tc = ~t;      // a late change must not leak into the product
      lat = 0;
      rdy_low = 1'b1;
      while (!bus.out_valid && lat < 100) begin
         if (bus.in_ready) rdy_low = 1'b0;
         tick();
         lat++;
      end
      repeat (hold) tick();
      p = bus.prod;
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   initial begin
      logic [31:0] p, p0, exp;
      int          lat, sa, sb;
      longint      ua, ub;
      bit          rl, stable;
      logic        t;
      logic [15:0] x, y;

      vecs[0]  = '{1'b1, 16'h0003, 16'h0005, 32'h0000_000F};
      vecs[1]  = '{1'b1, 16'h8000, 16'h8000, 32'h4000_0000};
      vecs[2]  = '{1'b1, 16'hFFFD, 16'h0007, 32'hFFFF_FFEB};
      vecs[3]  = '{1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
      vecs[4]  = '{1'b1, 16'hFFFF, 16'hFFFF, 32'h0000_0001};
      vecs[5]  = '{1'b1, 16'h0006, 16'hFFF9, 32'hFFFF_FFD6};
      vecs[6]  = '{1'b0, 16'h0000, 16'h1234, 32'h0000_0000};
      vecs[7]  = '{1'b0, 16'h8000, 16'h0002, 32'h0001_0000};
      vecs[8]  = '{1'b1, 16'h8000, 16'h0002, 32'hFFFF_0000};
      vecs[9]  = '{1'b0, 16'h1234, 16'h0010, 32'h0001_2340};
      vecs[10] = '{1'b1, 16'h7FFF, 16'h7FFF, 32'h3FFF_0001};
      vecs[11] = '{1'b1, 16'h7FFF, 16'h8000, 32'hC000_8000};
      vecs[12] = '{1'b0, 16'hFFFF, 16'h0001, 32'h0000_FFFF};
      vecs[13] = '{1'b1, 16'hFFFF, 16'h0001, 32'hFFFF_FFFF};
      vecs[14] = '{1'b0, 16'h0100, 16'h0100, 32'h0001_0000};

      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      bus.a = '0; bus.b = '0; bus.tc = 1'b0;

      // Reset values
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      chk("reset_in_ready",  64'(bus.in_ready),  64'd1);
      chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
      chk("reset_busy",      64'(bus.busy),      64'd0);
      chk("reset_prod",      64'(bus.prod),      64'd0);

      // Directed vector table. Each entry checks the product, the latency and in_ready.
      for (int i = 0; i < 15; i++) begin
         do_op(vecs[i].tc, vecs[i].a, vecs[i].b, i % 3, p, lat, rl);
         chk($sformatf("vec%0d_prod", i), 64'(p), 64'(vecs[i].exp));
         chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd17);
         chk($sformatf("vec%0d_in_ready_low", i), 64'(rl), 64'd1);
         chk($sformatf("vec%0d_back_idle", i), 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'b100);
      end

      // Hold DONE with out_ready low. A new in_valid must be ignored.
      bus.tc = 1'b1; bus.a = 16'h0003; bus.b = 16'h0005; bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 100) begin tick(); lat++; end
      chk("hold_reach_done", 64'(bus.out_valid), 64'd1);
      p0 = bus.prod;
      bus.in_valid = 1'b1; bus.a = 16'h0009; bus.b = 16'h0009;
      stable = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (!bus.out_valid || bus.prod !== p0 || bus.in_ready || !bus.busy) stable = 1'b0;
      end
      chk("hold_stable", 64'(stable), 64'd1);
      chk("hold_prod", 64'(bus.prod), 64'h0000_000F);
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk("hold_release", 64'({bus.in_ready, bus.out_valid}), 64'b10);

      // Reset in the middle of CALC (cnt=8) discards the result. A good product is then computed.
      bus.tc = 1'b1; bus.a = 16'h0064; bus.b = 16'h0064; bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      repeat (8) tick();
      chk("midcalc_busy", 64'(bus.busy), 64'd1);
      rst = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      rst = 1'b0;
      bus.out_ready = 1'b0;
      chk("midcalc_rst_state", 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'b100);
      chk("midcalc_rst_prod", 64'(bus.prod), 64'd0);
      repeat (25) tick();
      chk("midcalc_no_late_valid", 64'(bus.out_valid), 64'd0);
      do_op(1'b1, 16'h0006, 16'hFFF9, 0, p, lat, rl);
      chk("after_rst_prod", 64'(p), 64'h0000_0000_FFFF_FFD6);

      // Reset has priority over in_valid.
      bus.in_valid = 1'b1; bus.a = 16'h0002; bus.b = 16'h0002;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.in_valid = 1'b0;
      chk("rst_prio_idle", 64'({bus.in_ready, bus.busy}), 64'b10);
      repeat (20) tick();
      chk("rst_prio_no_valid", 64'(bus.out_valid), 64'd0);

      // Short randomised sweep against the integer reference
      for (int r = 0; r < 200; r++) begin
         t = 1'($urandom_range(0, 1));
         x = 16'($urandom);
         y = 16'($urandom);
         if (r % 10 == 0) x = 16'hFFFF;
         if (r % 10 == 5) y = 16'h8000;
         repeat ($urandom_range(0, 3)) tick();
         do_op(t, x, y, $urandom_range(0, 3), p, lat, rl);
         if (t) begin
            sa = int'($signed(x));
            sb = int'($signed(y));
            exp = 32'(sa * sb);
         end else begin
            ua = longint'(x);
            ub = longint'(y);
            exp = 32'(ua * ub);
         end
         chk($sformatf("rand%0d_tc%0d_%h_x_%h", r, t, x, y), 64'(p), 64'(exp));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
